// File: rtl/cache_array_ctrl.sv
// Direct-mapped LC-3b cache controller; line data lives in an external array, tag/valid/dirty live here.
// Optional build macro CACHE_ARRAY_CTRL_PERF_EN adds saturating hit_count/miss_count outputs.
module cache_array_ctrl #(
    parameter int LINE_W = 128,
    parameter int IDX_W  = 3,
    parameter int TAG_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       mem_address,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_byte_enable,
    input  logic [15:0]       mem_wdata,
    output logic [15:0]       mem_rdata,
    output logic              mem_resp,
    output logic [15:0]       pmem_address,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [IDX_W-1:0]  arr_index,
    output logic              arr_write,
    output logic [LINE_W-1:0] arr_datain,
    input  logic [LINE_W-1:0] arr_dataout
`ifdef CACHE_ARRAY_CTRL_PERF_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    localparam int LINES = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } state_t;

    state_t           state;
    logic [TAG_W-1:0] tags [LINES];
    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;

    logic [TAG_W-1:0] addr_tag;
    logic [IDX_W-1:0] idx;
    logic [2:0]       word;
    logic             req;
    logic             is_write;
    logic             hit;
    logic [LINE_W-1:0] merged;
    logic             addr_unused;

    assign addr_tag    = mem_address[15 -: TAG_W];
    assign idx         = mem_address[4 +: IDX_W];
    assign word        = mem_address[3:1];
    assign addr_unused = mem_address[0];
    assign req         = mem_read | mem_write;
    assign is_write    = mem_write;
    assign hit         = valid[idx] && (tags[idx] == addr_tag);
    assign arr_index   = idx;

    // Read-modify-write of the selected word: only enabled byte lanes take CPU data.
    always_comb begin
        merged = arr_dataout;
        if (mem_byte_enable[0]) merged[{word, 4'b0000} +: 8] = mem_wdata[7:0];
        if (mem_byte_enable[1]) merged[{word, 4'b1000} +: 8] = mem_wdata[15:8];
    end

    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata    = 16'h0000;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {addr_tag, idx, 4'b0000};
        pmem_wdata   = '0;
        arr_write    = 1'b0;
        arr_datain   = merged;
        case (state)
            IDLE: begin
                if (req && hit) begin
                    mem_resp = 1'b1;
                    if (is_write) arr_write = 1'b1;
                    else          mem_rdata = arr_dataout[{word, 4'b0000} +: 16];
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tags[idx], idx, 4'b0000};
                pmem_wdata   = arr_dataout;
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    arr_write  = 1'b1;
                    arr_datain = pmem_rdata;
                end
            end
            default: ;
        endcase
    end

    // After a fill the held request returns through IDLE and completes there as a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
            for (int i = 0; i < LINES; i++) tags[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            if (is_write) dirty[idx] <= 1'b1;
                        end else if (dirty[idx]) begin
                            state <= WRITEBACK;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        dirty[idx] <= 1'b0;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        tags[idx]  <= addr_tag;
                        valid[idx] <= 1'b1;
                        dirty[idx] <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_ARRAY_CTRL_PERF_EN
    logic miss_pending;
    logic miss_start;

    assign miss_start = (state == IDLE) && req && !hit;

    // The response that finishes a miss is not a hit, so miss_pending suppresses it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count    <= 16'h0000;
            miss_count   <= 16'h0000;
            miss_pending <= 1'b0;
        end else begin
            if (miss_start) begin
                miss_pending <= 1'b1;
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'h0001;
            end
            if (mem_resp) begin
                if (miss_pending) miss_pending <= 1'b0;
                else if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: doc/cache_array_ctrl.md
Name: cache_array_ctrl

Overview:
- Direct-mapped cache controller that drives an external 8-entry × 128-bit line-storage array over an index/write/datain/dataout interface.
- Sits between the LC-3b datapath (16-bit word port) and physical memory (128-bit line port).
- Keeps tag/valid/dirty state internally; the array itself holds only line data.
- Handles hits, clean-miss fills and dirty-miss writebacks.

Parameters:
- LINE_W, 128, line width in bits; must match the array width.
- IDX_W, 3, index width; 2^IDX_W lines.
- TAG_W, 9, tag width; equals 16 - IDX_W - 4.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mem_address  in  16  CPU byte address: [15:7] tag, [6:4] index, [3:1] word select, [0] ignored
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable  in  2  write byte lanes: [1] high byte, [0] low byte
- mem_wdata  in  16  CPU write data
- mem_rdata  out  16  CPU read data
- mem_resp  out  1  one-cycle completion strobe
- pmem_address  out  16  line-aligned memory address, [3:0]=0
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- pmem_wdata  out  128  writeback line
- pmem_rdata  in  128  fill line
- pmem_resp  in  1  memory completion strobe
- arr_index  out  3  array line index
- arr_write  out  1  array write enable, sampled at posedge clk
- arr_datain  out  128  array write data
- arr_dataout  in  128  array read data, combinational from arr_index

Behaviour:
- Reset (async, rst=1): state=IDLE; all valid and dirty bits = 0; tags = 0; mem_resp, pmem_read, pmem_write, arr_write = 0.
- arr_index = mem_address[6:4] in every state.
- States: IDLE, WRITEBACK, FILL.
- IDLE, no request: all strobes 0.
- IDLE, hit (valid[idx] and tag[idx] == addr tag):
  - mem_resp = 1 in the same cycle (combinational).
  - Read: mem_rdata = arr_dataout word selected by mem_address[3:1].
  - Write: arr_write = 1; arr_datain = arr_dataout with enabled bytes of the selected word replaced by mem_wdata; dirty[idx] set at the clock edge.
- IDLE, miss, dirty[idx] = 1: go to WRITEBACK.
- IDLE, miss, dirty[idx] = 0: go to FILL.
- WRITEBACK:
  - pmem_write = 1; pmem_address = {tag[idx], idx, 4'b0}; pmem_wdata = arr_dataout.
  - On pmem_resp: clear dirty[idx], go to FILL.
- FILL:
  - pmem_read = 1; pmem_address = {addr tag, idx, 4'b0}.
  - On pmem_resp: arr_write = 1, arr_datain = pmem_rdata; tag[idx] = addr tag; valid = 1; dirty = 0; go to IDLE.
  - The request then hits in IDLE on the following cycle.
- Miss latency: 1 + writeback cycles + fill cycles + 1 (hit cycle).
- mem_read and mem_write both high: treated as a write.
- A request dropping mid-miss is illegal; the controller still completes the line transfer.
- pmem_resp outside WRITEBACK/FILL is ignored.
- rst mid-operation: immediate return to IDLE with all lines invalid; an in-flight pmem transfer is abandoned and its strobes drop asynchronously.
- mem_rdata = 0 when not responding to a read.

Optional Feature:
- Macro: CACHE_ARRAY_CTRL_PERF_EN.
- Defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - hit_count increments on each mem_resp whose request entered IDLE as a hit.
  - miss_count increments on each IDLE→WRITEBACK or IDLE→FILL transition.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then read 0x0010 with pmem returning line 0x...0BEEF after 3 cycles → pmem_read with pmem_address = 0x0010; array written at index 1; mem_rdata = 0xBEEF; mem_resp one cycle after the fill.
- Read 0x0012 immediately after → mem_resp in the same cycle, no pmem activity, mem_rdata = word 1 of the filled line.
- Write 0x0014 with data 0x1234 and byte_enable 2'b01 on a hit → arr_write = 1; only byte 4 of the line becomes 0x34; mem_resp the same cycle; line dirty.
- Read 0x0094 (same index 1, new tag) → pmem_write first at 0x0010 carrying the modified line, then pmem_read at 0x0090; mem_resp after the fill.
- Assert rst during FILL → pmem_read drops immediately; a subsequent read of 0x0090 misses again.
- With CACHE_ARRAY_CTRL_PERF_EN defined, run the sequence above → hit_count = 2, miss_count = 2 before the reset; both 0 after the reset.
